// File: rtl/cprv_arb_pkg.sv
// cprv_arb_pkg: shared FSM/owner types, default widths and lane-index helpers
// for the instruction/data memory arbiter.
package cprv_arb_pkg;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // Which port issued the transaction currently in flight.
  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

  // Default port widths of the core memory interface.
  localparam int unsigned CPRV_DATA_WIDTH  = 64;
  localparam int unsigned CPRV_ADDR_WIDTH  = 64;
  localparam int unsigned CPRV_INSTR_WIDTH = 32;

  // Lowest fetch-address bit of the instruction lane index: the byte offset
  // inside one instruction word sits below it.
  function automatic int unsigned lane_lsb(input int unsigned instr_width);
    return $clog2(instr_width / 8);
  endfunction

  // Number of instruction words packed in one memory word.
  function automatic int unsigned lane_count(input int unsigned data_width,
                                             input int unsigned instr_width);
    return data_width / instr_width;
  endfunction

  // Width of the lane index; kept at least one bit so the lane register
  // always exists even when a memory word holds a single instruction.
  function automatic int unsigned lane_bits(input int unsigned data_width,
                                            input int unsigned instr_width);
    int unsigned n;
    n = data_width / instr_width;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cprv_rr_arb2.sv
// cprv_rr_arb2: two-input round-robin grant. Bit 0 is the instruction port,
// bit 1 the data port. The pointer starts favouring the data port and, after
// every accepted grant, flips to favour the port that did not win.
module cprv_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // 1 = data port wins a tie, 0 = instruction port wins a tie.
  logic ptr_q, ptr_d;

  // Grant selection and next pointer; a lone requester wins regardless of ptr.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (req_i[1] && (!req_i[0] || ptr_q)) begin
      gnt_o = 2'b10;
    end else if (req_i[0]) begin
      gnt_o = 2'b01;
    end
    if (accept_i) begin
      // Instruction won -> favour data next time, and vice versa.
      ptr_d = gnt_o[0];
    end
  end

  // Pointer register, reset to favour the data port.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cprv_mem_arbiter.sv
// cprv_mem_arbiter: shares one single-port valid/ready memory between the
// instruction-fetch port and the data port. One transaction at a time:
// IDLE (arbitrate/accept) -> ISSUE (present request) -> RESP (route response).
// Responses are passed through combinationally, never buffered.
// Build option: define CPRV_ARB_DATA_PRIO_EN for fixed data-port priority
// (removes the round-robin pointer); default is 2-way round robin.
module cprv_mem_arbiter
  import cprv_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = CPRV_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = CPRV_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = CPRV_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // instruction fetch port
  input  logic                   i_req_valid,
  output logic                   i_req_ready,
  input  logic [ADDR_WIDTH-1:0]  i_req_addr,
  output logic                   i_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [INSTR_WIDTH-1:0] i_rsp_data,
  // data port
  input  logic                   d_req_valid,
  output logic                   d_req_ready,
  input  logic [ADDR_WIDTH-1:0]  d_req_addr,
  input  logic [DATA_WIDTH-1:0]  d_req_wdata,
  input  logic                   d_req_w_en,
  output logic                   d_rsp_valid,
  input  logic                   d_rsp_ready,
  output logic [DATA_WIDTH-1:0]  d_rsp_data,
  // memory port
  output logic                   m_req_valid,
  input  logic                   m_req_ready,
  output logic [ADDR_WIDTH-1:0]  m_req_addr,
  output logic [DATA_WIDTH-1:0]  m_req_wdata,
  output logic                   m_req_w_en,
  input  logic                   m_rsp_valid,
  output logic                   m_rsp_ready,
  input  logic [DATA_WIDTH-1:0]  m_rsp_data
);

  localparam int unsigned NUM_LANES = lane_count(DATA_WIDTH, INSTR_WIDTH);
  localparam int unsigned LANE_BITS = lane_bits(DATA_WIDTH, INSTR_WIDTH);
  localparam int unsigned LANE_LSB  = lane_lsb(INSTR_WIDTH);

  // Transaction context captured when a request is accepted.
  arb_state_t              state_q, state_d;
  arb_owner_t              owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    w_en_q,  w_en_d;
  logic [LANE_BITS-1:0]    lane_q,  lane_d;

  // Arbitration: bit 0 = instruction port, bit 1 = data port.
  logic [1:0]              req_vec;
  logic [1:0]              gnt;
  logic                    req_accept;

  logic [LANE_BITS-1:0]    req_lane;
  logic [INSTR_WIDTH-1:0]  rsp_lanes [NUM_LANES];

  // Lane of the fetched instruction inside the memory word.
  generate
    if (NUM_LANES > 1) begin : g_lane_idx
      assign req_lane = i_req_addr[LANE_LSB +: LANE_BITS];
    end else begin : g_lane_single
      assign req_lane = '0;
    end
  endgenerate

  // Split the memory word into instruction-sized lanes.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lanes
      assign rsp_lanes[gi] = m_rsp_data[gi*INSTR_WIDTH +: INSTR_WIDTH];
    end
  endgenerate

  // Requests only compete while idle and out of reset.
  assign req_vec = ((state_q == IDLE) && rst_n) ? {d_req_valid, i_req_valid} : 2'b00;

`ifdef CPRV_ARB_DATA_PRIO_EN
  // Fixed priority: data port always wins a tie.
  assign gnt = {req_vec[1], req_vec[0] & ~req_vec[1]};
`else
  cprv_rr_arb2 u_rr_arb (
    .clk      (clk),
    .rst_n_i  (rst_n),
    .req_i    (req_vec),
    .accept_i (req_accept),
    .gnt_o    (gnt)
  );
`endif

  // A grant is only ever given to a valid requester, so any grant is a handshake.
  assign req_accept = |gnt;

  // Next-state, context capture and handshake outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    w_en_d      = w_en_q;
    lane_d      = lane_q;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    m_req_valid = 1'b0;
    m_rsp_ready = 1'b0;
    i_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        i_req_ready = gnt[0];
        d_req_ready = gnt[1];
        if (gnt[1]) begin
          owner_d = OWN_DATA;
          addr_d  = d_req_addr;
          wdata_d = d_req_wdata;
          w_en_d  = d_req_w_en;
          state_d = ISSUE;
        end else if (gnt[0]) begin
          // Fetches are always reads with no store data.
          owner_d = OWN_INSTR;
          addr_d  = i_req_addr;
          wdata_d = '0;
          w_en_d  = 1'b0;
          lane_d  = req_lane;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        m_req_valid = 1'b1;
        if (m_req_ready) begin
          state_d = RESP;
        end
      end

      RESP: begin
        // Backpressure from the owning port goes straight to memory.
        if (owner_q == OWN_DATA) begin
          d_rsp_valid = m_rsp_valid;
          m_rsp_ready = d_rsp_ready;
        end else begin
          i_rsp_valid = m_rsp_valid;
          m_rsp_ready = i_rsp_ready;
        end
        if (m_rsp_valid && m_rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Every handshake signal is held low while reset is asserted, even
    // before the registers have been cleared by the reset edge.
    if (!rst_n) begin
      i_req_ready = 1'b0;
      d_req_ready = 1'b0;
      m_req_valid = 1'b0;
      m_rsp_ready = 1'b0;
      i_rsp_valid = 1'b0;
      d_rsp_valid = 1'b0;
    end
  end

  // State and captured-context registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_INSTR;
      addr_q  <= '0;
      wdata_q <= '0;
      w_en_q  <= 1'b0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      w_en_q  <= w_en_d;
      lane_q  <= lane_d;
    end
  end

  // Memory request fields come from the captured context; zero in reset.
  assign m_req_addr  = rst_n ? addr_q  : '0;
  assign m_req_wdata = rst_n ? wdata_q : '0;
  assign m_req_w_en  = rst_n ? w_en_q  : 1'b0;

  // Response data is a pure pass-through; only valid is steered by owner.
  assign i_rsp_data = rsp_lanes[lane_q];
  assign d_rsp_data = m_rsp_data;

endmodule

// File: tb/tb_cprv_mem_arbiter.sv
// tb_cprv_mem_arbiter: directed scoreboard bench for cprv_mem_arbiter with a
// zero-wait behavioural memory (stall and spurious-response knobs).
`timescale 1ns/1ps
module tb_cprv_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          i_req_valid, i_req_ready;
  logic [AW-1:0] i_req_addr;
  logic          i_rsp_valid, i_rsp_ready;
  logic [IW-1:0] i_rsp_data;
  logic          d_req_valid, d_req_ready;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata;
  logic          d_req_w_en;
  logic          d_rsp_valid, d_rsp_ready;
  logic [DW-1:0] d_rsp_data;
  logic          m_req_valid, m_req_ready;
  logic [AW-1:0] m_req_addr;
  logic [DW-1:0] m_req_wdata;
  logic          m_req_w_en;
  logic          m_rsp_valid, m_rsp_ready;
  logic [DW-1:0] m_rsp_data;

  cprv_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_w_en(d_req_w_en),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata), .m_req_w_en(m_req_w_en),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data)
  );

  // ---------------- behavioural memory ----------------
  logic          mem_stall;
  logic          spurious;
  logic          m_rsp_pend;
  logic [DW-1:0] mem_rdata;
  logic [63:0]   mem [16];

  assign m_req_ready = !mem_stall;
  assign m_rsp_valid = m_rsp_pend | spurious;
  assign m_rsp_data  = mem_rdata;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rsp_pend <= 1'b0;
      mem_rdata  <= '0;
      for (int k = 0; k < 16; k++) begin
        mem[k] <= (k == 0) ? 64'h1111_2222_3333_4444 : 64'h0;
      end
    end else begin
      if (m_req_valid && m_req_ready) begin
        m_rsp_pend <= 1'b1;
        if (m_req_w_en) begin
          mem[m_req_addr[6:3]] <= m_req_wdata;
          mem_rdata <= '0;
        end else begin
          mem_rdata <= mem[m_req_addr[6:3]];
        end
      end else if (m_rsp_pend && m_rsp_ready) begin
        m_rsp_pend <= 1'b0;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        w_en;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mreq_t;

  typedef struct packed {
    logic [63:0] data;
    logic        care;
  } drsp_t;

  mreq_t       exp_mreq [$];
  logic [31:0] exp_i [$];
  drsp_t       exp_d [$];

  int checks   = 0;
  int failures = 0;
  int i_rsp_cnt = 0;
  int d_rsp_cnt = 0;
  int last_i_rsp_cyc = 0;
  int acc_cyc = 0;

  mreq_t       mon_m;
  drsp_t       mon_d;
  logic [31:0] mon_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h expected nothing", name, act);
  endtask

  // Monitor: compare every handshake the DUT presents against the queues.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (m_req_valid && m_req_ready) begin
        if (exp_mreq.size() == 0) begin
          fail_now("mreq_unexpected", m_req_addr);
        end else begin
          mon_m = exp_mreq.pop_front();
          $display("mreq addr=0x%0h w_en=%0b wdata=0x%0h", m_req_addr, m_req_w_en, m_req_wdata);
          check("mreq_addr", m_req_addr, mon_m.addr);
          check("mreq_w_en", 64'(m_req_w_en), 64'(mon_m.w_en));
          check("mreq_wdata", m_req_wdata, mon_m.wdata);
        end
      end
      if (i_rsp_valid && d_rsp_valid) begin
        fail_now("both_rsp_valid", 64'({i_rsp_valid, d_rsp_valid}));
      end
      if (i_rsp_valid && i_rsp_ready) begin
        i_rsp_cnt++;
        last_i_rsp_cyc = cyc;
        if (exp_i.size() == 0) begin
          fail_now("irsp_unexpected", 64'(i_rsp_data));
        end else begin
          mon_i = exp_i.pop_front();
          $display("irsp data=0x%0h", i_rsp_data);
          check("irsp_data", 64'(i_rsp_data), 64'(mon_i));
        end
      end
      if (d_rsp_valid && d_rsp_ready) begin
        d_rsp_cnt++;
        if (exp_d.size() == 0) begin
          fail_now("drsp_unexpected", d_rsp_data);
        end else begin
          mon_d = exp_d.pop_front();
          $display("drsp data=0x%0h", d_rsp_data);
          if (mon_d.care) check("drsp_data", d_rsp_data, mon_d.data);
        end
      end
      if (i_req_valid && d_req_valid) begin
        check("loser_ready_low", 64'(i_req_ready & d_req_ready), 64'h0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic fetch_wait();
    bit got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = i_req_ready;
    end
    if (!got) fail_now("fetch_accept_timeout", i_req_addr);
    else acc_cyc = cyc;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [63:0] addr);
    i_req_addr  = addr;
    i_req_valid = 1'b1;
    fetch_wait();
  endtask

  task automatic do_data(input logic [63:0] addr, input logic [63:0] wdata, input logic wen);
    bit got = 1'b0;
    d_req_addr  = addr;
    d_req_wdata = wdata;
    d_req_w_en  = wen;
    d_req_valid = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = d_req_ready;
    end
    if (!got) fail_now("data_accept_timeout", addr);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = (exp_mreq.size() == 0) && (exp_i.size() == 0) && (exp_d.size() == 0);
    end
    if (!done) fail_now(name, 64'(exp_mreq.size() + exp_i.size() + exp_d.size()));
  endtask

  // Hard stop if something wedges the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int dcnt0;
  int rel_cyc;

  initial begin
    rst_n = 1'b0;
    i_req_valid = 1'b1; i_req_addr = '0;
    d_req_valid = 1'b1; d_req_addr = '0; d_req_wdata = '0; d_req_w_en = 1'b0;
    i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
    mem_stall = 1'b0; spurious = 1'b1;

    // Reset: everything quiet even with requests and a stray response present.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'({i_req_ready, d_req_ready}), 64'h0);
    check("rst_valids", 64'({i_rsp_valid, d_rsp_valid, m_req_valid, m_rsp_ready}), 64'h0);
    check("rst_mreq_addr", m_req_addr, 64'h0);
    check("rst_mreq_wdata", m_req_wdata, 64'h0);
    check("rst_mreq_w_en", 64'(m_req_w_en), 64'h0);
    @(posedge clk); #1;
    i_req_valid = 1'b0; d_req_valid = 1'b0; spurious = 1'b0; rst_n = 1'b1;

    // Single fetch from 0x4 -> upper lane; three-cycle occupancy.
    @(posedge clk); #1;
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h4, wdata: 64'h0});
    exp_i.push_back(32'h1111_2222);
    dcnt0 = d_rsp_cnt;
    do_fetch(64'h4);
    drain("t1_drain");
    check("t1_occupancy", 64'(last_i_rsp_cyc - acc_cyc), 64'd2);
    check("t1_no_drsp", 64'(d_rsp_cnt), 64'(dcnt0));

    // Data write then read-back of 0x10, then fetch of its upper lane.
    @(posedge clk); #1;
    exp_mreq.push_back('{w_en: 1'b1, addr: 64'h10, wdata: 64'hDEAD_BEEF_0000_0001});
    exp_d.push_back('{data: 64'h0, care: 1'b0});
    do_data(64'h10, 64'hDEAD_BEEF_0000_0001, 1'b1);
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h10, wdata: 64'h0});
    exp_d.push_back('{data: 64'hDEAD_BEEF_0000_0001, care: 1'b1});
    do_data(64'h10, 64'h0, 1'b0);
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h14, wdata: 64'h0});
    exp_i.push_back(32'hDEAD_BEEF);
    do_fetch(64'h14);
    drain("t2_drain");

    // Both ports busy for six requests: order comes from the arbitration policy.
    @(posedge clk); #1;
`ifdef CPRV_ARB_DATA_PRIO_EN
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h0,  wdata: 64'h0});
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h10, wdata: 64'h0});
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h18, wdata: 64'h0});
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h0,  wdata: 64'h0});
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h4,  wdata: 64'h0});
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h10, wdata: 64'h0});
`else
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h0,  wdata: 64'h0});  // D
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h0,  wdata: 64'h0});  // I
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h10, wdata: 64'h0});  // D
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h4,  wdata: 64'h0});  // I
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h18, wdata: 64'h0});  // D
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h10, wdata: 64'h0});  // I
`endif
    exp_i.push_back(32'h3333_4444);
    exp_i.push_back(32'h1111_2222);
    exp_i.push_back(32'h0000_0001);
    exp_d.push_back('{data: 64'h1111_2222_3333_4444, care: 1'b1});
    exp_d.push_back('{data: 64'hDEAD_BEEF_0000_0001, care: 1'b1});
    exp_d.push_back('{data: 64'h0, care: 1'b1});
    fork
      begin
        do_fetch(64'h0);
        do_fetch(64'h4);
        do_fetch(64'h10);
      end
      begin
        do_data(64'h0,  64'h0, 1'b0);
        do_data(64'h10, 64'h0, 1'b0);
        do_data(64'h18, 64'h0, 1'b0);
      end
    join
    drain("t3_drain");

    // Memory stall in ISSUE, then data-port backpressure in RESP.
    @(posedge clk); #1;
    mem_stall = 1'b1;
    d_rsp_ready = 1'b0;
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h10, wdata: 64'h0});
    exp_d.push_back('{data: 64'hDEAD_BEEF_0000_0001, care: 1'b1});
    do_data(64'h10, 64'h0, 1'b0);
    i_req_addr  = 64'h4;
    i_req_valid = 1'b1;
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h4, wdata: 64'h0});
    exp_i.push_back(32'h1111_2222);
    repeat (4) begin
      @(negedge clk);
      check("t4_issue_valid", 64'(m_req_valid), 64'h1);
      check("t4_issue_addr", m_req_addr, 64'h10);
      check("t4_issue_w_en", 64'(m_req_w_en), 64'h0);
      check("t4_issue_no_accept", 64'({i_req_ready, d_req_ready}), 64'h0);
    end
    @(posedge clk); #1;
    mem_stall = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      check("t4_resp_valid", 64'(d_rsp_valid), 64'h1);
      check("t4_rsp_ready_tracks", 64'(m_rsp_ready), 64'h0);
      check("t4_resp_no_accept", 64'(i_req_ready), 64'h0);
    end
    @(posedge clk); #1;
    d_rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_rsp_ready_follow", 64'(m_rsp_ready), 64'h1);
    fetch_wait();
    drain("t4_drain");

    // Reset while a data response is pending: abandoned, then fetch wins.
    @(posedge clk); #1;
    d_rsp_ready = 1'b0;
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h10, wdata: 64'h0});
    do_data(64'h10, 64'h0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_in_resp", 64'(d_rsp_valid), 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    i_req_addr  = 64'h4;
    i_req_valid = 1'b1;
    @(negedge clk);
    check("t5_reset_quiet", 64'({i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, m_req_valid, m_rsp_ready}), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    d_rsp_ready = 1'b1;
    rel_cyc = cyc;
    exp_mreq.push_back('{w_en: 1'b0, addr: 64'h4, wdata: 64'h0});
    exp_i.push_back(32'h1111_2222);
    fetch_wait();
    check("t5_fetch_first", 64'(acc_cyc), 64'(rel_cyc));
    drain("t5_drain");

    // Stray memory response while idle is ignored.
    @(posedge clk); #1;
    spurious = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_spurious_quiet", 64'({m_rsp_ready, i_rsp_valid, d_rsp_valid}), 64'h0);
    end
    @(posedge clk); #1;
    spurious = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cprv_mem_arbiter.md
Name: cprv_mem_arbiter

Overview:
- Shares one single-port memory (cprv_ram_1p_w style valid/ready request and response channels) between the core's instruction-fetch port and data port.
- Accepts one request at a time, forwards it to memory, waits for the memory response, and routes that response back to the requester that issued it.
- Sits between cprv_cpu and a unified instruction/data memory in the top level.

Parameters:
- DATA_WIDTH, 64, memory word and data-port width in bits.
- ADDR_WIDTH, 64, byte-address width on all ports.
- INSTR_WIDTH, 32, instruction-port response width; DATA_WIDTH must be an integer multiple of INSTR_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- i_req_valid  in  1  fetch request valid.
- i_req_ready  out  1  fetch request accepted.
- i_req_addr  in  ADDR_WIDTH  fetch byte address.
- i_rsp_valid  out  1  fetch response valid.
- i_rsp_ready  in  1  fetch response accepted.
- i_rsp_data  out  INSTR_WIDTH  instruction word.
- d_req_valid  in  1  data request valid.
- d_req_ready  out  1  data request accepted.
- d_req_addr  in  ADDR_WIDTH  data byte address.
- d_req_wdata  in  DATA_WIDTH  store data.
- d_req_w_en  in  1  1 = write, 0 = read.
- d_rsp_valid  out  1  data response valid.
- d_rsp_ready  in  1  data response accepted.
- d_rsp_data  out  DATA_WIDTH  load data.
- m_req_valid  out  1  memory request valid.
- m_req_ready  in  1  memory accepts request.
- m_req_addr  out  ADDR_WIDTH  memory address.
- m_req_wdata  out  DATA_WIDTH  memory write data.
- m_req_w_en  out  1  memory write enable.
- m_rsp_valid  in  1  memory response valid.
- m_rsp_ready  out  1  response accepted by arbiter.
- m_rsp_data  in  DATA_WIDTH  memory read data.

Behaviour:
- Handshake rule: a transfer occurs on a rising clk edge where valid && ready. Memory returns exactly one response per request, including writes; write response data is don't-care but is still delivered.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Arbitrate between i_req_valid and d_req_valid. Assert x_req_ready combinationally to the winner only, in the same cycle.
  - On handshake: latch addr, wdata and w_en into registers. Instruction requests always latch w_en=0, wdata=0. Record owner (INSTR/DATA) and instruction lane = i_req_addr[log2(DATA_WIDTH/8)-1:log2(INSTR_WIDTH/8)]. Go to ISSUE.
- ISSUE:
  - m_req_valid=1, driven by the latched fields. Both x_req_ready=0.
  - On m_req_ready, go to RESP.
- RESP:
  - m_rsp_ready = owner's x_rsp_ready. Owner's x_rsp_valid = m_rsp_valid; the other rsp_valid is 0.
  - i_rsp_data = lane-selected INSTR_WIDTH slice of m_rsp_data. d_rsp_data = m_rsp_data unmodified.
  - On the response handshake, go to IDLE.
- Minimum occupancy is 3 cycles per transaction. Responses are passed through combinationally and are never buffered.
- Arbitration (default): 2-way round robin. The pointer flips to favour the non-winner after each accepted request. With only one requester valid, that requester wins regardless of the pointer.
- Simultaneous valid on both ports in IDLE: the pointer decides. The loser's ready stays 0 and its request must be held stable (AXI-style rule).
- Reset values:
  - state=IDLE; pointer favours DATA; owner=INSTR; latched fields=0.
  - All ready and valid outputs are 0 during reset. m_req_* data fields are 0.
- Reset mid-transaction: the in-flight transaction is abandoned and no response is forwarded. The memory is reset on the same rst_n.
- Memory never responds in IDLE or ISSUE. If m_rsp_valid arrives there, it is ignored and m_rsp_ready stays 0.

Optional Feature:
- Macro: CPRV_ARB_DATA_PRIO_EN.
- Defined: fixed priority, DATA always wins a simultaneous request. The round-robin pointer and its flop are removed.
- Undefined: round robin as above.

Decomposition:
- Package cprv_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, RESP};
  - typedef enum arb_owner_t {OWN_INSTR, OWN_DATA};
  - localparam for lane-index bit positions derived from DATA_WIDTH/INSTR_WIDTH.
- One sub-module: cprv_rr_arb2, a 2-input round-robin grant with pointer register. It is bypassed by the macro.

Test Plan:
- Single fetch at addr 0x4 with memory word 0x1111_2222_3333_4444 → i_rsp_data=0x1111_2222 (upper lane); d_rsp_valid never asserts; 3-cycle occupancy with a zero-wait memory.
- Data write addr 0x10, wdata 0xDEAD_BEEF_0000_0001, then data read of 0x10 → m_req_w_en=1 then 0; read returns 0xDEAD_BEEF_0000_0001 on d_rsp_data.
- Both ports valid continuously for 6 requests → grants D,I,D,I,D,I (round robin). With CPRV_ARB_DATA_PRIO_EN defined → D×6 while instruction port stalls.
- m_req_ready held low 4 cycles in ISSUE, then d_rsp_ready held low 3 cycles in RESP → m_req_* stable throughout; m_rsp_ready tracks d_rsp_ready; no new request is accepted until the response handshake.
- rst_n asserted low during RESP → next cycle state=IDLE, all valid/ready outputs 0; after release, a pending fetch is granted first (pointer=DATA, only I valid).
- Spurious m_rsp_valid in IDLE → m_rsp_ready=0; no x_rsp_valid pulse.
